multdiv_issue_ctrl: RTL and testbench

//  Pipeline-side initiator for the iterative multiply/divide unit: accepts one mul/div from execute,

---
 rtl/multdiv_issue_ctrl_pkg.sv | 30 +++
 rtl/multdiv_issue_ctrl_reg.sv | 20 ++
 rtl/multdiv_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and constants for the mul/div issue controller.
// State encoding, default exception codes and the rstatus register index.
package multdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int EXC_MUL_DEF = 4;
  localparam int EXC_DIV_DEF = 5;
  localparam int EXC_TMO_DEF = 6;

  localparam logic [4:0] RSTATUS_REG = 5'd30;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        div;
  } op_t;

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] data;
  } wb_t;

endpackage

// File: rtl/multdiv_issue_ctrl_reg.sv
// Enable flop register with asynchronous active-high clear.
// Holds its value whenever the enable is low.
module multdiv_issue_ctrl_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      o_q <= '0;
    else if (i_en)
      o_q <= i_d;
  end

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issues one mul/div to the iterative unit, stalls the pipe until
// the unit answers (or times out), then strobes a one-cycle writeback.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int EXC_MUL        = EXC_MUL_DEF,
  parameter int EXC_DIV        = EXC_DIV_DEF,
  parameter int EXC_TMO        = EXC_TMO_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_mult,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mult;
  logic          r_div;
  logic          r_tmo;

  op_t  w_op_d;
  op_t  w_op_q;
  wb_t  w_wb_d;
  wb_t  w_wb_q;
  logic w_acc;
  logic w_busy;
  logic w_tmo_hit;
  logic w_cap;

  assign w_acc = (r_state == S_IDLE) & op_valid
               & (op_is_mult | op_is_div) & ~flush & ~reset;
  assign w_busy = (r_state == S_BUSY) & ~flush;
  assign w_tmo_hit = w_busy & ~data_resultRDY
                   & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_cap = (w_busy & data_resultRDY) | w_tmo_hit;

  assign w_op_d = '{a: op_a, b: op_b, rd: op_rd, div: op_is_div};

  always_comb begin
    w_wb_d = '{rg: RSTATUS_REG, data: 32'(EXC_TMO)};
    if (data_resultRDY) begin
      if (data_exception)
        w_wb_d.data = w_op_q.div ? 32'(EXC_DIV) : 32'(EXC_MUL);
      else
        w_wb_d = '{rg: w_op_q.rd, data: data_result};
    end
  end

  multdiv_issue_ctrl_reg #(.W($bits(op_t))) u_op_reg (
    .clock (clock),
    .reset (reset),
    .i_en  (w_acc),
    .i_d   (w_op_d),
    .o_q   (w_op_q)
  );

  multdiv_issue_ctrl_reg #(.W($bits(wb_t))) u_wb_reg (
    .clock (clock),
    .reset (reset),
    .i_en  (w_cap),
    .i_d   (w_wb_d),
    .o_q   (w_wb_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mult  <= 1'b0;
      r_div   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_mult <= 1'b0;
      r_div  <= 1'b0;
      r_tmo  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_START;
            r_div   <= op_is_div;
            r_mult  <= ~op_is_div;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= flush ? S_IDLE : S_BUSY;
        end
        S_BUSY: begin
          if (r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
          if (flush)
            r_state <= S_IDLE;
          else if (data_resultRDY)
            r_state <= S_DONE;
          else if (w_tmo_hit) begin
            r_state <= S_DONE;
            r_tmo   <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Flush landing on the DONE cycle squashes the writeback strobe.
  assign ctrl_MULT     = r_mult;
  assign ctrl_DIV      = r_div;
  assign data_operandA = w_op_q.a;
  assign data_operandB = w_op_q.b;
  assign stall         = (r_state == S_START) | (r_state == S_BUSY) | w_acc;
  assign wb_valid      = (r_state == S_DONE) & ~flush;
  assign timeout       = r_tmo & ~flush;
  assign wb_reg        = w_wb_q.rg;
  assign wb_data       = w_wb_q.data;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Randomised and directed checks of multdiv_issue_ctrl against an
// operation-level reference model kept in this bench.
module tb_multdiv_issue_ctrl;

  localparam int TMO = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid, op_is_mult, op_is_div;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        flush;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        stall, wb_valid, timeout;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_is_mult(op_is_mult), .op_is_div(op_is_div),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .flush(flush),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .wb_data(wb_data), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: an in-flight op is described by its age in cycles
  // since acceptance (1 = start pulse cycle, >=2 = waiting on the unit).
  bit          m_act, m_done, m_tmo, m_div;
  int          m_age;
  logic [31:0] m_a, m_b, m_wbd;
  logic [4:0]  m_rd, m_wbr;

  // Unit stand-in and statistics
  bit          rand_mode = 0;
  bit          arm = 0;
  int          cnt = 0;
  int          cur_lat;
  bit          cur_exc;
  logic [31:0] cur_res;
  int          n_stall, n_mult, n_div, n_wb, n_tmo;
  logic [31:0] obs_data;
  logic [4:0]  obs_reg;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_act = 0; m_done = 0; m_tmo = 0; m_div = 0; m_age = 0;
    m_a = 0; m_b = 0; m_rd = 0; m_wbd = 0; m_wbr = 0;
  endtask

  task automatic compare();
    bit idle, acc;
    if (reset) model_clear();
    idle = !m_act && !m_done;
    acc = idle && op_valid && (op_is_mult || op_is_div) && !flush && !reset;
    chk("stall", stall, m_act || acc);
    chk("ctrl_MULT", ctrl_MULT, m_act && m_age == 1 && !m_div);
    chk("ctrl_DIV", ctrl_DIV, m_act && m_age == 1 && m_div);
    chk("operandA", data_operandA, m_a);
    chk("operandB", data_operandB, m_b);
    chk("wb_valid", wb_valid, m_done && !flush);
    chk("timeout", timeout, m_done && m_tmo && !flush);
    chk("wb_reg", wb_reg, m_wbr);
    chk("wb_data", wb_data, m_wbd);
    if (stall) n_stall++;
    if (ctrl_MULT) n_mult++;
    if (ctrl_DIV) n_div++;
    if (timeout) n_tmo++;
    if (wb_valid) begin
      n_wb++;
      obs_reg = wb_reg;
      obs_data = wb_data;
    end
    if (ctrl_MULT || ctrl_DIV) arm = 1;
  endtask

  task automatic model_update();
    if (reset) begin
      model_clear();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_act) begin
      if (flush) m_act = 0;
      else if (m_age == 1) m_age = 2;
      else if (data_resultRDY) begin
        m_act = 0; m_done = 1; m_tmo = 0;
        if (data_exception) begin
          m_wbr = 5'd30; m_wbd = m_div ? 32'd5 : 32'd4;
        end else begin
          m_wbr = m_rd; m_wbd = data_result;
        end
      end else if (m_age - 2 == TMO - 1) begin
        m_act = 0; m_done = 1; m_tmo = 1;
        m_wbr = 5'd30; m_wbd = 32'd6;
      end else m_age++;
    end else if (op_valid && (op_is_mult || op_is_div) && !flush) begin
      m_act = 1; m_age = 1; m_div = op_is_div;
      m_a = op_a; m_b = op_b; m_rd = op_rd;
    end
  endtask

  task automatic step();
    @(negedge clock);
    compare();
    @(posedge clock);
    model_update();
    #1;
    if (arm) begin
      if (rand_mode) begin
        cur_lat = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 45));
        cur_exc = ($urandom % 5 == 0);
        cur_res = $urandom;
      end
      cnt = cur_lat;
      arm = 0;
    end
    if (cnt > 0) begin
      data_resultRDY = (cnt == 1);
      data_result = cur_res;
      data_exception = cur_exc;
      cnt--;
    end else begin
      data_resultRDY = rand_mode && ($urandom % 20 == 0);
      data_exception = rand_mode && ($urandom % 2 == 0);
      data_result = $urandom;
    end
  endtask

  task automatic clr_stats();
    n_stall = 0; n_mult = 0; n_div = 0; n_wb = 0; n_tmo = 0;
    obs_reg = 0; obs_data = 0;
  endtask

  task automatic issue(bit mul, bit dv, logic [31:0] a, logic [31:0] b,
                       logic [4:0] rd, int lat, bit exc, logic [31:0] res);
    cur_lat = lat; cur_exc = exc; cur_res = res;
    op_valid = 1; op_is_mult = mul; op_is_div = dv;
    op_a = a; op_b = b; op_rd = rd;
    clr_stats();
    step();
    op_valid = 0; op_is_mult = 0; op_is_div = 0;
  endtask

  task automatic wait_wb(int max);
    for (int i = 0; i < max && n_wb == 0; i++) step();
    chk("wb_seen", n_wb, 1);
  endtask

  initial begin
    reset = 1; op_valid = 0; op_is_mult = 0; op_is_div = 0;
    op_a = 0; op_b = 0; op_rd = 0; flush = 0;
    data_result = 0; data_exception = 0; data_resultRDY = 0;
    model_clear();
    clr_stats();
    step(); step();
    chk("reset_stall", stall, 0);
    chk("reset_wb_data", wb_data, 0);
    reset = 0;
    step();

    // 7*6, answer 32 cycles after the start pulse
    issue(1, 0, 7, 6, 5'd5, 32, 0, 42);
    wait_wb(60);
    chk("mul_stall_cycles", n_stall, 34);
    chk("mul_pulses", n_mult, 1);
    chk("mul_wb_reg", obs_reg, 5);
    chk("mul_wb_data", obs_data, 42);

    // divide by zero
    issue(0, 1, 100, 0, 5'd7, 10, 1, 0);
    wait_wb(60);
    chk("div0_wb_reg", obs_reg, 30);
    chk("div0_wb_data", obs_data, 5);
    chk("div0_pulses", n_div, 1);

    // multiply overflow, operand changes while busy
    issue(1, 0, 32'h40000000, 4, 5'd9, 8, 1, 0);
    step(); step(); step();
    op_a = 32'h12345678;
    step();
    chk("opA_held", data_operandA, 32'h40000000);
    wait_wb(60);
    chk("ovf_wb_reg", obs_reg, 30);
    chk("ovf_wb_data", obs_data, 4);

    // unit never answers
    issue(1, 0, 3, 3, 5'd3, 0, 0, 0);
    wait_wb(80);
    chk("tmo_pulses", n_tmo, 1);
    chk("tmo_wb_data", obs_data, 6);
    chk("tmo_stall_cycles", n_stall, 42);

    // flush five cycles into the wait, then a clean op
    issue(1, 0, 8, 8, 5'd4, 10, 0, 99);
    for (int i = 0; i < 6; i++) step();
    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 10; i++) step();
    chk("flush_no_wb", n_wb, 0);
    issue(1, 0, 3, 3, 5'd2, 3, 0, 9);
    wait_wb(30);
    chk("post_flush_pulses", n_mult, 1);
    chk("post_flush_data", obs_data, 9);

    // both kinds set: divide wins
    issue(1, 1, 77, 7, 5'd6, 4, 0, 11);
    wait_wb(30);
    chk("both_div", n_div, 1);
    chk("both_mul", n_mult, 0);

    // reset in the middle of a wait
    issue(1, 0, 5, 5, 5'd8, 20, 0, 25);
    for (int i = 0; i < 5; i++) step();
    reset = 1;
    #1;
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_opA", data_operandA, 0);
    step();
    reset = 0;
    for (int i = 0; i < 25; i++) step();
    chk("rst_mid_no_wb", n_wb, 0);

    rand_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      op_valid = ($urandom % 3 == 0);
      op_is_mult = $urandom % 2;
      op_is_div = $urandom % 2;
      op_a = $urandom; op_b = $urandom; op_rd = 5'($urandom);
      flush = ($urandom % 40 == 0);
      reset = ($urandom % 300 == 0);
      step();
    end
    reset = 0; flush = 0; op_valid = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
